fp_ex_unit: RTL and testbench
=============================

Name: fp_ex_unit

Overview:
- Multi-cycle single-precision floating-point execute unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the EX-stage operands, the ALU control field and the FP flag, and computes fadd, fsub or fmul.
- Holds the pipeline with a stall output until the result is ready, then presents the result and destination register to the EX/MEM boundary.

Parameters:
CANON_NAN, 32'h7FC00000, value returned when any operand has exponent 255.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  FP op present in EX (FPE && !FPlwE && !FPswE); sampled only in IDLE.
op  in  3  ALUControlE encoding: 000 fadd, 001 fsub, 010 fmul, others unsupported.
a  in  32  operand 1 (RD1E after forwarding), IEEE-754 single.
b  in  32  operand 2 (RD2E after forwarding).
rd  in  5  destination register (RdE).
stall  out  1  freezes PC, IF/ID and ID/EX and bubbles EX/MEM; combinational.
done  out  1  one-cycle pulse; result and rd_out valid in this cycle.
result  out  32  FP result, held until the next accepted start.
rd_out  out  5  rd captured at start.

Behaviour:
- Reset values: state=IDLE, done=0, result=0, rd_out=0; stall=0 while reset=1.
- States: IDLE -> UNPACK -> EXEC -> NORM -> DONE -> IDLE, one cycle each.
- Accept rule: start=1 in IDLE (cycle N) latches a, b, op and rd, then moves to UNPACK.
- Timing: stall is high in cycles N..N+3; DONE occurs at N+4 with done=1 and stall=0, so ID/EX advances at the end of N+4. Latency is 4 cycles.
- stall = (state==IDLE && start) || state in {UNPACK, EXEC, NORM}.
- start is ignored outside IDLE. A start still high in DONE (same instruction) does not re-launch, because DONE always returns to IDLE.
- UNPACK: split sign, 8-bit exponent and 24-bit mantissa with the hidden 1.
  - Exponent 0 is treated as zero (flush-to-zero, denormal inputs).
  - Exponent 255 on either operand forces result=CANON_NAN.
  - fsub inverts the sign of b.
- EXEC, add/sub:
  - Swap so the larger magnitude comes first.
  - Right-shift the smaller mantissa by the exponent difference; shifts >=25 give 0.
  - Add on equal signs, subtract on different signs. Sum width is 25 bits.
- EXEC, mul:
  - Sign = sa^sb; exponent = ea+eb-127 in 10-bit signed; product = 24x24 -> 48 bits.
  - Either operand zero gives a signed zero.
- NORM:
  - Carry out: shift right 1, exponent+1.
  - Otherwise leading-zero-count and left shift until bit 23 is set.
  - Rounding is truncation (round toward zero); discarded bits are dropped.
- Boundary results:
  - Exact add/sub zero -> +0 (32'h00000000).
  - Final exponent >=255 -> signed infinity {s, 8'hFF, 23'h0}.
  - Final exponent <=0 -> signed zero.
- Unsupported op: still runs the 4-cycle sequence and returns result=0.
- Reset mid-operation: return to IDLE on the next edge with done=0 and stall=0; the partial result is discarded and result/rd_out clear to 0.
- Simultaneous reset and start: reset wins.

Decomposition:
- Shared package holds:
  - op encodings FOP_ADD=3'b000, FOP_SUB=3'b001, FOP_MUL=3'b010;
  - state encoding (IDLE, UNPACK, EXEC, NORM, DONE);
  - constants EXP_BIAS=127, EXP_MAX=255, CANON_NAN.
- One natural sub-module: fp_lzc24, a combinational 24-bit leading-zero counter (5-bit output) used by NORM.

Test Plan:
- fadd 0x3F800000 + 0x40000000, rd=5 -> stall high 4 cycles; done at N+4 with result=0x40400000, rd_out=5.
- fsub 0x3F800000 - 0x3F800000 -> result=0x00000000. fsub 0x40400000 - 0x3F800000 -> 0x40000000.
- fmul 0x3FC00000 * 0x40000000 -> 0x40400000. fmul 0x7F000000 * 0x7F000000 -> 0x7F800000 (overflow to +inf). fmul 0x00800000 * 0x00800000 -> 0x00000000 (underflow).
- fadd 0x7F800001 + 0x3F800000 -> CANON_NAN. fadd 0x00000001 + 0x3F800000 -> 0x3F800000 (denormal flushed).
- start held high through DONE and one further cycle -> exactly one done pulse. A second start arriving in IDLE at N+5 launches a new op with done at N+9.
- reset asserted at N+2 of an fmul -> from N+3: stall=0, done=0, result=0, state IDLE. A start at N+4 completes normally at N+8.

Source files
------------

// File: rtl/fp_ex_unit_pkg.sv
// Shared encodings and constants for the EX-stage floating-point unit.
package fp_ex_unit_pkg;

    localparam logic [2:0] FOP_ADD = 3'b000;
    localparam logic [2:0] FOP_SUB = 3'b001;
    localparam logic [2:0] FOP_MUL = 3'b010;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        EXEC   = 3'd2,
        NORM   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int          EXP_BIAS  = 127;
    localparam int          EXP_MAX   = 255;
    localparam logic [31:0] CANON_NAN = 32'h7FC00000;

endpackage

// File: rtl/fp_ex_unit_lzc24.sv
// Combinational leading-zero counter for a 24-bit mantissa; all-zero input yields 24.
module fp_lzc24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);

    // Ascending scan so the most significant set bit is the last to write count.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (value[i]) count = 5'(23 - i);
        end
    end

endmodule

// File: rtl/fp_ex_unit.sv
// Multi-cycle single-precision fadd/fsub/fmul execute unit; stalls the pipeline for four cycles per op.
module fp_ex_unit #(
    parameter logic [31:0] CANON_NAN = fp_ex_unit_pkg::CANON_NAN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  rd,
    output logic        stall,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);
    import fp_ex_unit_pkg::*;

    state_t state, state_nxt;
    logic   accept;

    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;

    logic        sa_p0, sb_p0, nan_p0;
    logic [7:0]  ea_p0, eb_p0;
    logic [23:0] ma_p0, mb_p0;

    logic               sign_p1, mzero_p1;
    logic signed [9:0]  exp_p1;
    logic [24:0]        sum_p1;
    logic [47:0]        prod_p1;

    logic        is_mul, is_addsub;
    logic        a_big;
    logic [7:0]  e_big, e_small, diff;
    logic [23:0] m_big, m_small, m_shift;
    logic [24:0] sum_w;
    logic [47:0] prod_w;
    logic signed [9:0] exp_mul_w;

    logic [4:0]  lz;
    logic [23:0] norm_m;
    logic [31:0] res_nxt;
    logic        unused_bits;

    assign accept    = (state == IDLE) && start;
    assign is_mul    = (op_q == FOP_MUL);
    assign is_addsub = (op_q == FOP_ADD) || (op_q == FOP_SUB);

    assign stall = !reset && (accept || state == UNPACK || state == EXEC || state == NORM);
    assign done  = !reset && (state == DONE);

    function automatic logic [31:0] pack_trunc(input logic s, input logic signed [9:0] e,
                                               input logic [22:0] frac);
        if (e >= 10'(EXP_MAX))
            return {s, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            return {s, 31'd0};
        else
            return {s, e[7:0], frac};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            result <= 32'd0;
            rd_out <= 5'd0;
        end else begin
            state <= state_nxt;
            if (accept)        rd_out <= rd;
            if (state == NORM) result <= res_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = UNPACK;
            UNPACK:  state_nxt = EXEC;
            EXEC:    state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture at accept
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
        end
    end

    // UNPACK -> p0: flush denormals, hidden bit, NaN/Inf detect, fsub sign flip
    always_ff @(posedge clk) begin
        if (state == UNPACK) begin
            sa_p0  <= a_q[31];
            sb_p0  <= b_q[31] ^ (op_q == FOP_SUB);
            ea_p0  <= a_q[30:23];
            eb_p0  <= b_q[30:23];
            ma_p0  <= (a_q[30:23] == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
            mb_p0  <= (b_q[30:23] == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
            nan_p0 <= (a_q[30:23] == 8'hFF) || (b_q[30:23] == 8'hFF);
        end
    end

    always_comb begin
        a_big   = {ea_p0, ma_p0} >= {eb_p0, mb_p0};
        e_big   = a_big ? ea_p0 : eb_p0;
        e_small = a_big ? eb_p0 : ea_p0;
        m_big   = a_big ? ma_p0 : mb_p0;
        m_small = a_big ? mb_p0 : ma_p0;
        diff    = e_big - e_small;
        m_shift = (diff >= 8'd25) ? 24'd0 : (m_small >> diff);
        sum_w   = (sa_p0 == sb_p0) ? ({1'b0, m_big} + {1'b0, m_shift})
                                   : ({1'b0, m_big} - {1'b0, m_shift});
        prod_w    = ma_p0 * mb_p0;
        exp_mul_w = $signed({2'b00, ea_p0}) + $signed({2'b00, eb_p0}) - 10'(EXP_BIAS);
    end

    // EXEC -> p1: aligned sum or full product with unnormalised exponent
    always_ff @(posedge clk) begin
        if (state == EXEC) begin
            sign_p1  <= is_mul ? (sa_p0 ^ sb_p0) : (a_big ? sa_p0 : sb_p0);
            exp_p1   <= is_mul ? exp_mul_w : $signed({2'b00, e_big});
            mzero_p1 <= (ea_p0 == 8'd0) || (eb_p0 == 8'd0);
            sum_p1   <= sum_w;
            prod_p1  <= prod_w;
        end
    end

    fp_lzc24 u_lzc (
        .value (sum_p1[23:0]),
        .count (lz)
    );

    assign norm_m      = sum_p1[23:0] << lz;
    assign unused_bits = ^{prod_p1[22:0], norm_m[23]};

    // NORM: renormalise, truncate, and apply zero/inf/NaN boundaries
    always_comb begin
        res_nxt = 32'd0;
        if (!is_mul && !is_addsub)
            res_nxt = 32'd0;
        else if (nan_p0)
            res_nxt = CANON_NAN;
        else if (is_mul) begin
            if (mzero_p1)
                res_nxt = {sign_p1, 31'd0};
            else if (prod_p1[47])
                res_nxt = pack_trunc(sign_p1, exp_p1 + 10'sd1, prod_p1[46:24]);
            else
                res_nxt = pack_trunc(sign_p1, exp_p1, prod_p1[45:23]);
        end else begin
            if (sum_p1 == 25'd0)
                res_nxt = 32'd0;
            else if (sum_p1[24])
                res_nxt = pack_trunc(sign_p1, exp_p1 + 10'sd1, sum_p1[23:1]);
            else
                res_nxt = pack_trunc(sign_p1, exp_p1 - $signed({5'd0, lz}), norm_m[22:0]);
        end
    end

endmodule

// File: tb/tb_fp_ex_unit.sv
// Directed bench for fp_ex_unit: stall/done timing checks plus a result scoreboard.
module tb_fp_ex_unit;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        stall, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int pushes   = 0;
    int cnt0;
    logic [36:0] sb_q[$];
    logic [36:0] sb_e;

    fp_ex_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd     (rd),
        .stall  (stall),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every done pulse retires the oldest expected result
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("result", result, sb_e[36:5]);
                chk("rd_out", {27'd0, rd_out}, {27'd0, sb_e[4:0]});
            end
        end
    end

    task automatic op_seq(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] r,
                          input logic [31:0] expv, input bit hold);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; rd = r;
        sb_q.push_back({expv, r});
        pushes++;
        #1 chk({tag, "_stall_N"}, {31'd0, stall}, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (!hold) begin
                start = 1'b0;
                op = 3'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom);
            end
            #1;
            chk({tag, "_stall_busy"}, {31'd0, stall}, 32'd1);
            chk({tag, "_done_busy"},  {31'd0, done},  32'd0);
        end
        @(negedge clk);
        #1;
        chk({tag, "_done_N4"},  {31'd0, done},  32'd1);
        chk({tag, "_stall_N4"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; op = 3'b000;
        a = 32'h3F800000; b = 32'h40000000; rd = 5'd3;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall",  {31'd0, stall}, 32'd0);
        chk("rst_done",   {31'd0, done},  32'd0);
        chk("rst_result", result,         32'd0);
        chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        #1 chk("idle_stall", {31'd0, stall}, 32'd0);

        op_seq("fadd_1_2",   3'b000, 32'h3F800000, 32'h40000000, 5'd5,  32'h40400000, 1'b0);
        op_seq("fsub_zero",  3'b001, 32'h3F800000, 32'h3F800000, 5'd6,  32'h00000000, 1'b0);
        op_seq("fsub_3_1",   3'b001, 32'h40400000, 32'h3F800000, 5'd7,  32'h40000000, 1'b0);
        op_seq("fmul_1p5_2", 3'b010, 32'h3FC00000, 32'h40000000, 5'd8,  32'h40400000, 1'b0);
        op_seq("fmul_ovf",   3'b010, 32'h7F000000, 32'h7F000000, 5'd9,  32'h7F800000, 1'b0);
        op_seq("fmul_unf",   3'b010, 32'h00800000, 32'h00800000, 5'd10, 32'h00000000, 1'b0);
        op_seq("fadd_nan",   3'b000, 32'h7F800001, 32'h3F800000, 5'd11, 32'h7FC00000, 1'b0);
        op_seq("fadd_denrm", 3'b000, 32'h00000001, 32'h3F800000, 5'd12, 32'h3F800000, 1'b0);
        op_seq("fmul_nzero", 3'b010, 32'h80000000, 32'h3F800000, 5'd17, 32'h80000000, 1'b0);
        op_seq("unsup_op",   3'b111, 32'h3F800000, 32'h3F800000, 5'd13, 32'h00000000, 1'b0);
        op_seq("fadd_ninf",  3'b000, 32'hFF000000, 32'hFF000000, 5'd18, 32'hFF800000, 1'b0);

        cnt0 = done_cnt;
        op_seq("hold_once",  3'b000, 32'h40000000, 32'h40000000, 5'd14, 32'h40800000, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #1 chk("single_done_pulse", done_cnt - cnt0, 32'd1);

        op_seq("b2b_first",  3'b000, 32'h3F800000, 32'h3F800000, 5'd15, 32'h40000000, 1'b1);
        op_seq("b2b_second", 3'b010, 32'h40000000, 32'h40400000, 5'd16, 32'h40C00000, 1'b0);

        // fmul interrupted by reset in its EXEC cycle
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 32'h3FC00000; b = 32'h40000000; rd = 5'd20;
        #1 chk("mid_stall_N", {31'd0, stall}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1 chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_post_stall",  {31'd0, stall},  32'd0);
        chk("mid_post_done",   {31'd0, done},   32'd0);
        chk("mid_post_result", result,          32'd0);
        chk("mid_post_rd_out", {27'd0, rd_out}, 32'd0);
        op_seq("after_rst",  3'b000, 32'h40400000, 32'h3F800000, 5'd21, 32'h40800000, 1'b0);

        repeat (6) @(negedge clk);
        #1;
        chk("sb_empty",    sb_q.size(), 32'd0);
        chk("total_dones", done_cnt,    pushes);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
